// File: rtl/id_ex_control.sv
// ID/EX pipeline control register for a five-stage MIPS-style core.
// Decodes the ID-stage opcode into EX/MEM/WB controls, registers them together
// with the register specifiers and funct field, and optionally detects
// load-use hazards.
// Build option: define LOAD_USE_STALL_EN to include load-use hazard detection;
// without it hazard_stall is tied low and software fills load delay slots.
module id_ex_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        id_valid,
    input  logic        ex_hold,
    input  logic        flush,
    output logic [1:0]  alu_op,
    output logic [5:0]  funct_ex,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        branch,
    output logic [4:0]  rs_ex,
    output logic [4:0]  rt_ex,
    output logic [4:0]  rd_ex,
    output logic        ex_valid,
    output logic        illegal_ex,
    output logic        hazard_stall
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // An all-zero value of this struct is the bubble.
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ex_t;

    logic [5:0] opcode;
    ex_t        dec;
    ex_t        ex_d;
    ex_t        ex_q;

    // shamt is not needed by the EX control path
    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

    assign opcode = instr[31:26];

    // Opcode decode into a fully populated ID/EX entry
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.funct = instr[5:0];
        dec.rs    = instr[25:21];
        dec.rt    = instr[20:16];
        dec.rd    = instr[15:11];
        case (opcode)
            OP_RTYPE: begin
                dec.alu_op    = 2'b10;
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_op     = 2'b00;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op = 2'b01;
                dec.branch = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_SLTI: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

`ifdef LOAD_USE_STALL_EN
    logic uses_rt;

    // Load in EX whose destination feeds the ID instruction; a flushed ID
    // instruction never stalls
    always_comb begin
        uses_rt      = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
        hazard_stall = !flush && id_valid && ex_q.valid && ex_q.mem_read &&
                       (ex_q.rt != 5'd0) &&
                       ((ex_q.rt == instr[25:21]) || (uses_rt && (ex_q.rt == instr[20:16])));
    end
`else
    assign hazard_stall = 1'b0;
`endif

    // ID/EX next value by priority: flush, hold, stall bubble, new instruction
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (ex_hold) begin
            ex_d = ex_q;
        end else if (hazard_stall) begin
            ex_d = '0;
        end else if (id_valid) begin
            ex_d = dec;
        end else begin
            ex_d = '0;
        end
    end

    // ID/EX register with synchronous reset to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign alu_op     = ex_q.alu_op;
    assign funct_ex   = ex_q.funct;
    assign reg_dst    = ex_q.reg_dst;
    assign alu_src    = ex_q.alu_src;
    assign mem_read   = ex_q.mem_read;
    assign mem_write  = ex_q.mem_write;
    assign mem_to_reg = ex_q.mem_to_reg;
    assign reg_write  = ex_q.reg_write;
    assign branch     = ex_q.branch;
    assign rs_ex      = ex_q.rs;
    assign rt_ex      = ex_q.rt;
    assign rd_ex      = ex_q.rd;
    assign ex_valid   = ex_q.valid;
    assign illegal_ex = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_control.sv
// Self-checking bench for id_ex_control: instruction-level reference model
// compared every cycle, plus hand-computed expectations on directed vectors.
module tb_id_ex_control;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        id_valid;
    logic        ex_hold;
    logic        flush;
    logic [1:0]  alu_op;
    logic [5:0]  funct_ex;
    logic        reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic        ex_valid, illegal_ex, hazard_stall;

    int checks = 0;
    int errors = 0;

`ifdef LOAD_USE_STALL_EN
    localparam logic HZ = 1'b1;
`else
    localparam logic HZ = 1'b0;
`endif

    localparam logic [31:0] I_LW   = 32'h8D280000;  // lw   rs9 rt8
    localparam logic [31:0] I_ADD  = 32'h010B5020;  // add  rs8 rt11 rd10
    localparam logic [31:0] I_SW   = 32'hAD280004;  // sw   rs9 rt8
    localparam logic [31:0] I_ADDI = 32'h21280005;  // addi rs9 rt8
    localparam logic [31:0] I_BEQ  = 32'h10220003;  // beq  rs1 rt2
    localparam logic [31:0] I_SLTI = 32'h292A0005;  // slti rs9 rt10
    localparam logic [31:0] I_ILL  = 32'hFC000000;  // opcode 111111

    id_ex_control dut (
        .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid),
        .ex_hold(ex_hold), .flush(flush), .alu_op(alu_op), .funct_ex(funct_ex),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .branch(branch), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .ex_valid(ex_valid), .illegal_ex(illegal_ex), .hazard_stall(hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic       ill;
        logic [1:0] aop;
        logic       rdst, asrc, mrd, mwr, m2r, rwr, br;
        logic [5:0] fn;
        logic [4:0] rs, rt, rd;
    } ex_t;

    ex_t m;
    bit  m_init = 0;

    function automatic ex_t m_decode(input logic [31:0] i);
        ex_t e = '0;
        e.v  = 1'b1;
        e.fn = i[5:0];
        e.rs = i[25:21];
        e.rt = i[20:16];
        e.rd = i[15:11];
        case (i[31:26])
            6'd0:  begin e.aop = 2'd2; e.rdst = 1; e.rwr = 1; end
            6'd35: begin e.asrc = 1; e.mrd = 1; e.m2r = 1; e.rwr = 1; end
            6'd43: begin e.asrc = 1; e.mwr = 1; end
            6'd4:  begin e.aop = 2'd1; e.br = 1; end
            6'd8:  begin e.asrc = 1; e.rwr = 1; end
            6'd10: begin e.aop = 2'd3; e.asrc = 1; e.rwr = 1; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic logic m_hazard(input ex_t e, input logic [31:0] i,
                                      input logic v, input logic f);
        logic urt;
        urt = (i[31:26] == 6'd0) || (i[31:26] == 6'd43) || (i[31:26] == 6'd4);
        if (HZ == 1'b0 || f || !v || !e.v || !e.mrd || e.rt == 5'd0) return 1'b0;
        return (e.rt == i[25:21]) || (urt && e.rt == i[20:16]);
    endfunction

    // model advances on the same edge as the DUT
    always @(posedge clk) begin
        if (rst) begin
            m = '0;
            m_init = 1;
        end else if (flush) begin
            m = '0;
        end else if (ex_hold) begin
            m = m;
        end else if (m_hazard(m, instr, id_valid, flush)) begin
            m = '0;
        end else if (id_valid) begin
            m = m_decode(instr);
        end else begin
            m = '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle once the model is initialised
    always @(negedge clk) begin
        if (m_init) begin
            check("m.alu_op",     32'(alu_op),       32'(m.aop));
            check("m.funct_ex",   32'(funct_ex),     32'(m.fn));
            check("m.reg_dst",    32'(reg_dst),      32'(m.rdst));
            check("m.alu_src",    32'(alu_src),      32'(m.asrc));
            check("m.mem_read",   32'(mem_read),     32'(m.mrd));
            check("m.mem_write",  32'(mem_write),    32'(m.mwr));
            check("m.mem_to_reg", 32'(mem_to_reg),   32'(m.m2r));
            check("m.reg_write",  32'(reg_write),    32'(m.rwr));
            check("m.branch",     32'(branch),       32'(m.br));
            check("m.rs_ex",      32'(rs_ex),        32'(m.rs));
            check("m.rt_ex",      32'(rt_ex),        32'(m.rt));
            check("m.rd_ex",      32'(rd_ex),        32'(m.rd));
            check("m.ex_valid",   32'(ex_valid),     32'(m.v));
            check("m.illegal_ex", 32'(illegal_ex),   32'(m.ill));
            check("m.hazard",     32'(hazard_stall),
                  32'(m_hazard(m, instr, id_valid, flush)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input logic r, input logic [31:0] i, input logic v,
                          input logic h, input logic f);
        rst = r; instr = i; id_valid = v; ex_hold = h; flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] tbl [10];

    initial begin
        tbl[0] = I_LW;  tbl[1] = I_ADD;  tbl[2] = I_SW;  tbl[3] = I_ADDI;
        tbl[4] = I_BEQ; tbl[5] = I_SLTI; tbl[6] = I_ILL; tbl[7] = 32'h8C480000;
        tbl[8] = 32'h00000020; tbl[9] = 32'h8D200000;

        // reset with a lw presented
        set_in(1, I_LW, 1, 0, 0);
        tick(); tick();
        check("rst.ex_valid",  32'(ex_valid),  0);
        check("rst.mem_read",  32'(mem_read),  0);
        check("rst.rt_ex",     32'(rt_ex),     0);
        check("rst.reg_write", 32'(reg_write), 0);
        check("rst.hazard",    32'(hazard_stall), 0);

        // lw then add: load-use
        set_in(0, I_LW, 1, 0, 0);
        #1 check("lw.hazard0", 32'(hazard_stall), 0);
        tick();
        check("lw.mem_read",   32'(mem_read),   1);
        check("lw.mem_to_reg", 32'(mem_to_reg), 1);
        check("lw.rt_ex",      32'(rt_ex),      8);
        set_in(0, I_ADD, 1, 0, 0);
        #1 check("add.hazard", 32'(hazard_stall), 32'(HZ));
        tick();
        check("add.bubble_or_add", 32'(ex_valid), 1 - 32'(HZ));
        if (HZ) begin
            #1 check("add.hazard_fall", 32'(hazard_stall), 0);
            tick();
        end
        check("add.alu_op", 32'(alu_op),   2);
        check("add.funct",  32'(funct_ex), 32'h20);
        check("add.rd_ex",  32'(rd_ex),    10);

        // lw then sw: rt match through uses_rt
        set_in(0, I_LW, 1, 0, 0); tick();
        set_in(0, I_SW, 1, 0, 0);
        #1 check("sw.hazard", 32'(hazard_stall), 32'(HZ));
        tick(); tick();
        check("sw.mem_write", 32'(mem_write), 1);

        // lw then addi rs9 rt8: rt not a source, no stall
        set_in(0, I_LW, 1, 0, 0); tick();
        set_in(0, I_ADDI, 1, 0, 0);
        #1 check("addi.hazard", 32'(hazard_stall), 0);
        tick();
        check("addi.alu_src", 32'(alu_src), 1);
        check("addi.rt_ex",   32'(rt_ex),   8);

        // flush masks a real hazard, then beq squashed
        set_in(0, I_LW, 1, 0, 0); tick();
        set_in(0, I_ADD, 1, 0, 1);
        #1 check("flush.hazard", 32'(hazard_stall), 0);
        tick();
        set_in(0, I_BEQ, 1, 0, 1); tick();
        check("beqf.ex_valid", 32'(ex_valid), 0);
        check("beqf.branch",   32'(branch),   0);
        set_in(0, I_BEQ, 1, 0, 0); tick();
        check("beq.alu_op", 32'(alu_op), 1);
        check("beq.rt_ex",  32'(rt_ex),  2);

        // slti under a 3-cycle hold
        set_in(0, I_SLTI, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold.branch", 32'(branch), 1);
            check("hold.rs_ex",  32'(rs_ex),  1);
        end
        set_in(0, I_SLTI, 1, 0, 0); tick();
        check("slti.alu_op",  32'(alu_op),  3);
        check("slti.alu_src", 32'(alu_src), 1);
        check("slti.rt_ex",   32'(rt_ex),   10);

        // hold together with a load-use hazard
        set_in(0, I_LW, 1, 0, 0); tick();
        set_in(0, I_ADD, 1, 1, 0); tick();
        check("hh.mem_read", 32'(mem_read), 1);
        #1 check("hh.hazard", 32'(hazard_stall), 32'(HZ));
        set_in(0, I_ADD, 1, 0, 0); tick();
        if (HZ) tick();
        check("hh.add", 32'(alu_op), 2);

        // reset during a hold/stall leaves nothing behind
        set_in(0, I_LW, 1, 0, 0); tick();
        set_in(0, I_ADD, 1, 1, 0); tick();
        set_in(1, I_ADD, 1, 1, 0); tick();
        check("rsth.ex_valid", 32'(ex_valid), 0);
        check("rsth.rt_ex",    32'(rt_ex),    0);
        set_in(0, I_ADD, 0, 0, 0);
        #1 check("rsth.hazard", 32'(hazard_stall), 0);
        tick();

        // illegal opcodes
        set_in(0, I_ILL, 1, 0, 0); tick();
        check("ill.illegal",   32'(illegal_ex), 1);
        check("ill.ex_valid",  32'(ex_valid),   1);
        check("ill.reg_write", 32'(reg_write),  0);
        check("ill.mem_write", 32'(mem_write),  0);
        set_in(0, 32'h0C000000, 1, 0, 0); tick();
        check("ill2.illegal", 32'(illegal_ex), 1);
        set_in(0, I_ADD, 0, 0, 0); tick();
        check("idle.ex_valid", 32'(ex_valid), 0);

        // mixed traffic checked against the model
        for (int n = 0; n < 300; n++) begin
            set_in($urandom_range(0, 49) == 0, tbl[$urandom_range(0, 9)],
                   $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 7) == 0);
            tick();
        end

        set_in(0, 32'h0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_control.md
ID_EX_CONTROL -- requirements
Module: id_ex_control

Interface
REQ-001 SHALL: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL: instr  input  32  ID-stage instruction (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0]).
REQ-004 SHALL: id_valid  input  1  instr holds a real instruction this cycle.
REQ-005 SHALL: ex_hold  input  1  downstream stall; ID/EX register keeps its contents.
REQ-006 SHALL: flush  input  1  branch squash; ID/EX register loads a bubble.
REQ-007 SHALL: alu_op  output  2  registered ALUOp to the ALU control decoder in EX.
REQ-008 SHALL: funct_ex  output  6  registered funct field to the ALU control decoder.
REQ-009 SHALL: reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch  outputs  1 each  registered EX/MEM/WB controls.
REQ-010 SHALL: rs_ex, rt_ex, rd_ex  outputs  5 each  registered register specifiers.
REQ-011 SHALL: ex_valid  output  1  EX stage holds a real instruction.
REQ-012 SHALL: illegal_ex  output  1  EX instruction had an undecoded opcode.
REQ-013 SHALL: hazard_stall  output  1  combinational; IF/ID and PC hold when high.

Function
REQ-014 SHALL decode opcode: 000000 R-type -> alu_op 10, reg_dst 1, reg_write 1; 100011 lw -> alu_op 00, alu_src 1, mem_read 1, mem_to_reg 1, reg_write 1; 101011 sw -> alu_op 00, alu_src 1, mem_write 1; 000100 beq -> alu_op 01, branch 1; 001000 addi -> alu_op 00, alu_src 1, reg_write 1; 001010 slti -> alu_op 11, alu_src 1, reg_write 1.
REQ-015 SHALL treat any other opcode as illegal: all controls 0, alu_op 00, ex_valid 1, illegal_ex 1.
REQ-016 SHALL pass funct, rs, rt, rd unchanged into the ID/EX register; latency ID -> EX exactly one cycle.
REQ-017 SHALL define a bubble as all controls 0, alu_op 00, ex_valid 0, illegal_ex 0, specifiers 0.
REQ-018 SHALL define uses_rt as 1 for R-type, sw, beq; 0 otherwise.
REQ-019 SHALL, with hazard detection enabled, drive hazard_stall = id_valid & ex_valid & mem_read & (rt_ex != 0) & (rt_ex == rs_id | (uses_rt & rt_ex == rt_id)).
REQ-020 SHALL update ID/EX by priority each edge: rst -> bubble; else flush -> bubble; else ex_hold -> hold; else hazard_stall -> bubble; else id_valid -> decoded instr; else bubble.
REQ-021 SHALL force hazard_stall 0 while flush is high (squashed instruction needs no stall).
REQ-022 SHALL, when ex_hold and hazard_stall are both high, hold ID/EX and keep hazard_stall asserted; the stall resolves after ex_hold drops.
REQ-023 SHALL limit any load-use stall to one cycle: the inserted bubble clears mem_read, so hazard_stall falls the following cycle.

Reset
REQ-024 SHALL, while rst is high at a clock edge, load the bubble; all registered outputs 0 the cycle after.
REQ-025 SHALL make hazard_stall 0 whenever the ID/EX register holds a bubble, including immediately after reset.
REQ-026 SHALL let rst mid-stall or mid-hold discard the held instruction with no residual state.

Configuration
REQ-027 SHALL compile load-use hazard detection only when macro LOAD_USE_STALL_EN is defined.
REQ-028 SHALL, without LOAD_USE_STALL_EN, tie hazard_stall to 0 and omit the hazard step in REQ-020; software scheduling then supplies load delay slots.

Verification
REQ-029 SHALL: rst 1 for 2 cycles with instr 0x8D280000, id_valid 1 -> all outputs 0, hazard_stall 0.
REQ-030 SHALL: lw 0x8D280000 then add 0x010B5020 (LOAD_USE_STALL_EN) -> cycle 2 hazard_stall 1, next EX a bubble; add reaches EX one cycle later with alu_op 10, funct_ex 100000, rd_ex 10.
REQ-031 SHALL: lw 0x8D280000 then sw 0xAD280004 -> hazard_stall 1 (rt match via uses_rt); lw then addi rs=9 rt=8 -> hazard_stall 0.
REQ-032 SHALL: beq 0x10220003 with flush 1 the same cycle -> EX holds bubble, ex_valid 0, hazard_stall 0.
REQ-033 SHALL: slti 0x292A0005 with ex_hold 1 for 3 cycles -> prior EX contents unchanged 3 cycles, then alu_op 11, alu_src 1.
REQ-034 SHALL: opcode 111111, id_valid 1 -> next cycle illegal_ex 1, ex_valid 1, reg_write 0, mem_write 0.
